mq_addr_manager: RTL and testbench



---
 rtl/mq_buf_pkg.sv | 18 +
 rtl/addr_free_fifo.sv | 49 ++++
 rtl/mq_addr_manager.sv | 176 +++++++++++++++++
 tb/tb_mq_addr_manager.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mq_buf_pkg.sv
// Shared types and helpers for the multi-queue buffer address manager.
package mq_buf_pkg;

   localparam int ADDR_WIDTH_DEF = 12;
   localparam int DEPTH          = 2**ADDR_WIDTH_DEF;
   localparam int CNT_WIDTH      = ADDR_WIDTH_DEF + 1;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   // Queue id width for n queues, never narrower than one bit.
   function automatic int qid_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/addr_free_fifo.sv
// Circular FIFO of free buffer word addresses. During init the write port is
// driven with a running index so the FIFO starts out holding every address.
module addr_free_fifo #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  init_we,
   input  logic [ADDR_WIDTH-1:0] init_data,
   input  logic                  push,
   input  logic [ADDR_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [ADDR_WIDTH-1:0] head,
   output logic [ADDR_WIDTH:0]   count
);

   localparam int FIFO_DEPTH = 2**ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_data;

   // Init and recycle pushes share one write port; they never overlap because
   // dequeues are ignored until init completes.
   assign wr_en   = init_we | push;
   assign wr_data = init_we ? init_data : push_data;
   assign head    = mem[rd_ptr];

   // Storage array, no reset so it maps onto distributed RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         count <= count + (ADDR_WIDTH+1)'(wr_en) - (ADDR_WIDTH+1)'(pop);
      end
   end

endmodule

// File: rtl/mq_addr_manager.sv
// Multi-queue linked-list address manager for the shared packet buffer.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_INIT | loading free FIFO with 0..DEPTH-1, enq/deq ignored
// ST_RUN  | normal operation, init_done=1
module mq_addr_manager
   import mq_buf_pkg::*;
#(
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int NUM_QUEUES     = 4,
   parameter int QID_WIDTH      = qid_width(NUM_QUEUES),
   parameter int FULL_THRESHOLD = 48,
   parameter int FULL_OFF       = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   output logic                                 init_done,
   input  logic                                 enq_valid,
   input  logic [QID_WIDTH-1:0]                 enq_qid,
   output logic                                 enq_ready,
   output logic [ADDR_WIDTH-1:0]                enq_addr,
   input  logic                                 deq_valid,
   input  logic [QID_WIDTH-1:0]                 deq_qid,
   output logic [ADDR_WIDTH-1:0]                deq_addr,
   output logic                                 deq_err,
   output logic [NUM_QUEUES-1:0]                q_empty,
   output logic [NUM_QUEUES*(ADDR_WIDTH+1)-1:0] q_count,
   output logic [ADDR_WIDTH:0]                  free_count,
   output logic                                 almost_full
);

   localparam int BUF_DEPTH = 2**ADDR_WIDTH;
   localparam int CNT_W     = ADDR_WIDTH + 1;

   state_t                state;
   logic [ADDR_WIDTH-1:0] init_cnt;

   logic [ADDR_WIDTH-1:0] head_q   [NUM_QUEUES];
   logic [ADDR_WIDTH-1:0] tail_q   [NUM_QUEUES];
   logic [CNT_W-1:0]      cnt_q    [NUM_QUEUES];
   logic [ADDR_WIDTH-1:0] link_mem [BUF_DEPTH];

   logic                  enq_qid_ok;
   logic                  deq_qid_ok;
   logic [QID_WIDTH-1:0]  enq_idx;
   logic [QID_WIDTH-1:0]  deq_idx;
   logic                  enq_fire;
   logic                  deq_fire;
   logic [NUM_QUEUES-1:0] enq_hit;
   logic [NUM_QUEUES-1:0] deq_hit;
   logic [CNT_W-1:0]      free_next;
   logic [CNT_W-1:0]      used_next;

   // Out-of-range ids are folded onto queue 0 for indexing only; the fire
   // terms below keep them from touching any state.
   assign enq_qid_ok = ({1'b0, enq_qid} < (QID_WIDTH+1)'(NUM_QUEUES));
   assign deq_qid_ok = ({1'b0, deq_qid} < (QID_WIDTH+1)'(NUM_QUEUES));
   assign enq_idx    = enq_qid_ok ? enq_qid : '0;
   assign deq_idx    = deq_qid_ok ? deq_qid : '0;

   // No same-cycle bypass from a dequeue into an empty free FIFO.
   assign enq_ready  = init_done & (free_count != '0);
   assign enq_fire   = enq_valid & enq_ready & enq_qid_ok;
   assign deq_fire   = deq_valid & init_done & deq_qid_ok & (cnt_q[deq_idx] != '0);
   assign deq_addr   = head_q[deq_idx];

   assign free_next  = free_count + CNT_W'(deq_fire) - CNT_W'(enq_fire);
   assign used_next  = CNT_W'(BUF_DEPTH) - free_next;

   addr_free_fifo #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_free_fifo (
      .clk       (clk),
      .rst       (rst),
      .init_we   (state == ST_INIT),
      .init_data (init_cnt),
      .push      (deq_fire),
      .push_data (deq_addr),
      .pop       (enq_fire),
      .head      (enq_addr),
      .count     (free_count)
   );

   // Per-queue decode of this cycle's accepted requests.
   always_comb begin
      enq_hit = '0;
      deq_hit = '0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
         enq_hit[q] = enq_fire & (enq_idx == QID_WIDTH'(q));
         deq_hit[q] = deq_fire & (deq_idx == QID_WIDTH'(q));
      end
   end

   // Init sequencer: walk every address into the free FIFO, then run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_INIT;
         init_cnt  <= '0;
         init_done <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               init_cnt <= init_cnt + 1'b1;
               if (init_cnt == ADDR_WIDTH'(BUF_DEPTH-1)) begin
                  state     <= ST_RUN;
                  init_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Head/tail/count update; a dequeue from a one-word queue that is also
   // being enqueued takes the new address straight into head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int q = 0; q < NUM_QUEUES; q++) begin
            head_q[q] <= '0;
            tail_q[q] <= '0;
            cnt_q[q]  <= '0;
         end
      end else begin
         for (int q = 0; q < NUM_QUEUES; q++) begin
            if (deq_hit[q])
               head_q[q] <= (enq_hit[q] && cnt_q[q] == CNT_W'(1)) ? enq_addr
                                                                  : link_mem[head_q[q]];
            else if (enq_hit[q] && cnt_q[q] == '0)
               head_q[q] <= enq_addr;
            if (enq_hit[q])
               tail_q[q] <= enq_addr;
            if (enq_hit[q] && !deq_hit[q])
               cnt_q[q] <= cnt_q[q] + 1'b1;
            else if (!enq_hit[q] && deq_hit[q])
               cnt_q[q] <= cnt_q[q] - 1'b1;
         end
      end
   end

   // Link table write: chain the new word behind the current tail. The entry
   // written is a tail and the entry read is a head, so they never collide.
   always_ff @(posedge clk) begin
      if (enq_fire && cnt_q[enq_idx] != '0)
         link_mem[tail_q[enq_idx]] <= enq_addr;
   end

   // Error pulse for any dequeue request that could not be honoured.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) deq_err <= 1'b0;
      else     deq_err <= deq_valid & ~deq_fire;
   end

   // Occupancy hysteresis, evaluated on the post-update occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         almost_full <= 1'b0;
      end else if (init_done) begin
         if (used_next > CNT_W'(BUF_DEPTH - FULL_THRESHOLD))
            almost_full <= 1'b1;
         else if (used_next <= CNT_W'(FULL_OFF))
            almost_full <= 1'b0;
      end
   end

   // Flatten per-queue status.
   always_comb begin
      q_empty = '0;
      q_count = '0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
         q_empty[q]               = (cnt_q[q] == '0);
         q_count[q*CNT_W +: CNT_W] = cnt_q[q];
      end
   end

endmodule

// File: tb/tb_mq_addr_manager.sv
// Self-checking bench for mq_addr_manager with a 16-word buffer and 4 queues.
module tb_mq_addr_manager;

   localparam int AW    = 4;
   localparam int NQ    = 4;
   localparam int QW    = 2;
   localparam int CW    = AW + 1;
   localparam int DEPTH = 16;
   localparam int FTHR  = 4;
   localparam int FOFF  = 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              init_done;
   logic              enq_valid = 1'b0;
   logic [QW-1:0]     enq_qid = '0;
   logic              enq_ready;
   logic [AW-1:0]     enq_addr;
   logic              deq_valid = 1'b0;
   logic [QW-1:0]     deq_qid = '0;
   logic [AW-1:0]     deq_addr;
   logic              deq_err;
   logic [NQ-1:0]     q_empty;
   logic [NQ*CW-1:0]  q_count;
   logic [CW-1:0]     free_count;
   logic              almost_full;

   mq_addr_manager #(
      .ADDR_WIDTH     (AW),
      .NUM_QUEUES     (NQ),
      .QID_WIDTH      (QW),
      .FULL_THRESHOLD (FTHR),
      .FULL_OFF       (FOFF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .init_done   (init_done),
      .enq_valid   (enq_valid),
      .enq_qid     (enq_qid),
      .enq_ready   (enq_ready),
      .enq_addr    (enq_addr),
      .deq_valid   (deq_valid),
      .deq_qid     (deq_qid),
      .deq_addr    (deq_addr),
      .deq_err     (deq_err),
      .q_empty     (q_empty),
      .q_count     (q_count),
      .free_count  (free_count),
      .almost_full (almost_full)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: address lists per queue and the free list, in order.
   int m_q [NQ][$];
   int m_free [$];
   bit m_init = 1'b0;
   bit m_af   = 1'b0;

   function automatic int m_used();
      return DEPTH - m_free.size();
   endfunction

   // One clock of stimulus, checked against the model before and after the edge.
   task automatic step(input bit ev, input int eq, input bit dv, input int dq,
                       output logic [AW-1:0] ga, output logic [AW-1:0] gd);
      bit rdy, eok, dok, err;
      int a;
      logic [NQ-1:0] exp_empty;
      enq_valid = ev;
      enq_qid   = QW'(eq);
      deq_valid = dv;
      deq_qid   = QW'(dq);
      #1;
      rdy = m_init && (m_free.size() != 0);
      dok = dv && m_init && (m_q[dq].size() != 0);
      eok = ev && rdy;
      err = dv && !dok;
      n_checks++;
      if (enq_ready !== rdy) begin
         n_fail++;
         $display("FAIL enq_ready: got %0b expected %0b", enq_ready, rdy);
      end
      if (rdy) begin
         n_checks++;
         if (enq_addr !== AW'(m_free[0])) begin
            n_fail++;
            $display("FAIL enq_addr: got %0d expected %0d", enq_addr, m_free[0]);
         end
      end
      if (dok) begin
         n_checks++;
         if (deq_addr !== AW'(m_q[dq][0])) begin
            n_fail++;
            $display("FAIL deq_addr q%0d: got %0d expected %0d", dq, deq_addr, m_q[dq][0]);
         end
      end
      ga = enq_addr;
      gd = deq_addr;
      @(posedge clk);
      #1;
      enq_valid = 1'b0;
      deq_valid = 1'b0;
      if (dok) begin
         a = m_q[dq].pop_front();
         m_free.push_back(a);
      end
      if (eok) begin
         a = m_free.pop_front();
         m_q[eq].push_back(a);
      end
      if (m_init) begin
         if (m_used() > DEPTH - FTHR) m_af = 1'b1;
         else if (m_used() <= FOFF)   m_af = 1'b0;
      end
      n_checks++;
      if (deq_err !== err) begin
         n_fail++;
         $display("FAIL deq_err: got %0b expected %0b", deq_err, err);
      end
      n_checks++;
      if (free_count !== CW'(m_free.size())) begin
         n_fail++;
         $display("FAIL free_count: got %0d expected %0d", free_count, m_free.size());
      end
      for (int i = 0; i < NQ; i++) begin
         exp_empty[i] = (m_q[i].size() == 0);
         n_checks++;
         if (q_count[i*CW +: CW] !== CW'(m_q[i].size())) begin
            n_fail++;
            $display("FAIL q_count[%0d]: got %0d expected %0d", i, q_count[i*CW +: CW], m_q[i].size());
         end
      end
      n_checks++;
      if (q_empty !== exp_empty) begin
         n_fail++;
         $display("FAIL q_empty: got %b expected %b", q_empty, exp_empty);
      end
      n_checks++;
      if (almost_full !== m_af) begin
         n_fail++;
         $display("FAIL almost_full: got %0b expected %0b", almost_full, m_af);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NQ; i++) m_q[i].delete();
      m_free.delete();
      m_init = 1'b0;
      m_af   = 1'b0;
   endtask

   task automatic model_loaded();
      m_free.delete();
      for (int i = 0; i < DEPTH; i++) m_free.push_back(i);
      m_init = 1'b1;
   endtask

   // Pulse reset, wait (bounded) for init, and load the model.
   task automatic reset_dut();
      int cyc;
      enq_valid = 1'b0;
      deq_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      cyc = 0;
      while (init_done !== 1'b1 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      n_checks++;
      if (cyc != DEPTH) begin
         n_fail++;
         $display("FAIL init_cycles: got %0d expected %0d", cyc, DEPTH);
      end
      model_loaded();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      n_checks++;
      if (init_done !== 1'b0 || enq_ready !== 1'b0 || deq_err !== 1'b0 || almost_full !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b%b%b%b expected 0000", init_done, enq_ready, deq_err, almost_full);
      end
      n_checks++;
      if (q_empty !== 4'hF || q_count !== '0 || free_count !== '0) begin
         n_fail++;
         $display("FAIL reset_queues: got empty=%b count=%h free=%0d expected F/0/0", q_empty, q_count, free_count);
      end
      reset_dut();
      n_checks++;
      if (free_count !== CW'(DEPTH) || enq_addr !== '0 || enq_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL after_init: got free=%0d addr=%0d rdy=%0b expected 16/0/1", free_count, enq_addr, enq_ready);
      end
   endtask

   task automatic test_fifo_order();
      logic [AW-1:0] ga, gd;
      reset_dut();
      for (int k = 0; k < 3; k++) begin
         step(1, 0, 0, 0, ga, gd);
         n_checks++;
         if (ga !== AW'(k)) begin
            n_fail++;
            $display("FAIL order_enq: got %0d expected %0d", ga, k);
         end
      end
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 1, 0, ga, gd);
         n_checks++;
         if (gd !== AW'(k)) begin
            n_fail++;
            $display("FAIL order_deq: got %0d expected %0d", gd, k);
         end
      end
      n_checks++;
      if (q_empty[0] !== 1'b1 || free_count !== CW'(16) || enq_addr !== AW'(3)) begin
         n_fail++;
         $display("FAIL order_end: got empty=%0b free=%0d next=%0d expected 1/16/3", q_empty[0], free_count, enq_addr);
      end
   endtask

   task automatic test_interleave();
      logic [AW-1:0] ga, gd;
      int exp_q2 [2] = '{1, 3};
      int exp_q1 [2] = '{0, 2};
      reset_dut();
      step(1, 1, 0, 0, ga, gd);
      step(1, 2, 0, 0, ga, gd);
      step(1, 1, 0, 0, ga, gd);
      step(1, 2, 0, 0, ga, gd);
      for (int k = 0; k < 2; k++) begin
         step(0, 0, 1, 2, ga, gd);
         n_checks++;
         if (gd !== AW'(exp_q2[k])) begin
            n_fail++;
            $display("FAIL interleave_q2: got %0d expected %0d", gd, exp_q2[k]);
         end
      end
      for (int k = 0; k < 2; k++) begin
         step(0, 0, 1, 1, ga, gd);
         n_checks++;
         if (gd !== AW'(exp_q1[k])) begin
            n_fail++;
            $display("FAIL interleave_q1: got %0d expected %0d", gd, exp_q1[k]);
         end
      end
      n_checks++;
      if (q_count !== '0) begin
         n_fail++;
         $display("FAIL interleave_counts: got %h expected 0", q_count);
      end
   endtask

   task automatic test_bypass();
      logic [AW-1:0] ga, gd;
      reset_dut();
      for (int k = 0; k < 5; k++) step(1, 1, 0, 0, ga, gd);
      step(1, 0, 0, 0, ga, gd);
      step(1, 0, 1, 0, ga, gd);
      n_checks++;
      if (gd !== AW'(5) || ga !== AW'(6) || q_count[CW-1:0] !== CW'(1)) begin
         n_fail++;
         $display("FAIL bypass: got deq=%0d enq=%0d cnt=%0d expected 5/6/1", gd, ga, q_count[CW-1:0]);
      end
      step(0, 0, 1, 0, ga, gd);
      n_checks++;
      if (gd !== AW'(6) || q_empty[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL bypass_head: got deq=%0d empty=%0b expected 6/1", gd, q_empty[0]);
      end
   endtask

   task automatic test_full();
      logic [AW-1:0] ga, gd;
      int qi, guard;
      reset_dut();
      for (int k = 1; k <= 16; k++) begin
         step(1, $urandom_range(0, NQ-1), 0, 0, ga, gd);
         if (k == 12 || k == 13) begin
            n_checks++;
            if (almost_full !== (k == 13)) begin
               n_fail++;
               $display("FAIL af_set after %0d enq: got %0b expected %0b", k, almost_full, k == 13);
            end
         end
      end
      n_checks++;
      if (enq_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_ready: got %0b expected 0", enq_ready);
      end
      step(1, 0, 0, 0, ga, gd);
      n_checks++;
      if (free_count !== '0) begin
         n_fail++;
         $display("FAIL full_ignore: got free=%0d expected 0", free_count);
      end
      qi = 0;
      while (m_q[qi].size() == 0) qi++;
      step(1, qi, 1, qi, ga, gd);
      n_checks++;
      if (free_count !== CW'(1)) begin
         n_fail++;
         $display("FAIL full_no_bypass: got free=%0d expected 1", free_count);
      end
      guard = 0;
      while (m_used() > 1 && guard < 40) begin
         guard++;
         qi = 0;
         while (m_q[qi].size() == 0) qi++;
         step(0, 0, 1, qi, ga, gd);
         if (m_used() <= 2) begin
            n_checks++;
            if (almost_full !== (m_used() == 2)) begin
               n_fail++;
               $display("FAIL af_clear at used %0d: got %0b expected %0b", m_used(), almost_full, m_used() == 2);
            end
         end
      end
   endtask

   task automatic test_error();
      logic [AW-1:0] ga, gd;
      reset_dut();
      step(1, 0, 0, 0, ga, gd);
      step(1, 0, 0, 0, ga, gd);
      step(0, 0, 1, 3, ga, gd);
      n_checks++;
      if (deq_err !== 1'b1 || free_count !== CW'(14) || q_count[CW-1:0] !== CW'(2)) begin
         n_fail++;
         $display("FAIL err_pulse: got err=%0b free=%0d cnt0=%0d expected 1/14/2", deq_err, free_count, q_count[CW-1:0]);
      end
      step(0, 0, 0, 0, ga, gd);
      n_checks++;
      if (deq_err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clear: got %0b expected 0", deq_err);
      end
   endtask

   task automatic test_reset_midrun();
      logic [AW-1:0] ga, gd;
      reset_dut();
      for (int k = 0; k < 5; k++) step(1, $urandom_range(0, NQ-1), 0, 0, ga, gd);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (init_done !== 1'b0 || q_empty !== 4'hF || q_count !== '0 || free_count !== '0) begin
         n_fail++;
         $display("FAIL midrun_rst: got done=%0b empty=%b free=%0d expected 0/F/0", init_done, q_empty, free_count);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      enq_valid = 1'b1;
      deq_valid = 1'b1;
      deq_qid   = 2'd2;
      for (int c = 1; c <= DEPTH; c++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (free_count !== CW'(c) || deq_err !== 1'b1 || init_done !== (c == DEPTH)) begin
            n_fail++;
            $display("FAIL reinit cycle %0d: got free=%0d err=%0b done=%0b", c, free_count, deq_err, init_done);
         end
      end
      enq_valid = 1'b0;
      deq_valid = 1'b0;
      model_loaded();
      step(0, 0, 0, 0, ga, gd);
      step(1, 3, 0, 0, ga, gd);
      n_checks++;
      if (ga !== '0) begin
         n_fail++;
         $display("FAIL reinit_first_addr: got %0d expected 0", ga);
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] ga, gd;
      reset_dut();
      for (int k = 0; k < 400; k++)
         step($urandom_range(0, 99) < 55, $urandom_range(0, NQ-1),
              $urandom_range(0, 99) < 50, $urandom_range(0, NQ-1), ga, gd);
   endtask

   initial begin
      test_reset();
      test_fifo_order();
      test_interleave();
      test_bypass();
      test_full();
      test_error();
      test_reset_midrun();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
